// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-side and response signals of alu_cmd_sequencer in one bundle.
// ALU_CMD_SEQ_OVF_EN adds the rsp_ovf response flag.
interface alu_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_sel;
    logic        cmd_shift;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_sel;
    logic        alu_shift;
    logic [31:0] alu_result;
    logic        alu_co;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_co;

`ifdef ALU_CMD_SEQ_OVF_EN
    logic        rsp_ovf;

    modport master (
        output cmd_valid, cmd_sel, cmd_shift, cmd_a, cmd_b, alu_result, alu_co, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, alu_shift, rsp_valid, rsp_data, rsp_co, rsp_ovf
    );
    modport slave (
        input  cmd_valid, cmd_sel, cmd_shift, cmd_a, cmd_b, alu_result, alu_co, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, alu_shift, rsp_valid, rsp_data, rsp_co, rsp_ovf
    );
`else
    modport master (
        output cmd_valid, cmd_sel, cmd_shift, cmd_a, cmd_b, alu_result, alu_co, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, alu_shift, rsp_valid, rsp_data, rsp_co
    );
    modport slave (
        input  cmd_valid, cmd_sel, cmd_shift, cmd_a, cmd_b, alu_result, alu_co, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, alu_shift, rsp_valid, rsp_data, rsp_co
    );
`endif
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus five-state sequencer feeding a two-cycle registered ALU.
// Define ALU_CMD_SEQ_OVF_EN to add the signed-overflow response flag rsp_ovf.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    alu_cmd_sequencer_if.slave bus_io
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, DRIVE, EXEC, CAPT, RESP} state_e;

    typedef struct packed {
        logic [1:0]  sel;
        logic        shift;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    cmd_t        mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        full, empty, push, pop;
    cmd_t        head;

    state_e      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [1:0]  alu_sel_q, alu_sel_d;
    logic        alu_shift_q, alu_shift_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_co_q, rsp_co_d;

    // The extra pointer MSB tells full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus_io.cmd_valid && !full;
    assign pop   = (state_q == IDLE) && !empty;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: storage has no reset; clearing the pointers is what empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{sel: bus_io.cmd_sel, shift: bus_io.cmd_shift,
                                         a: bus_io.cmd_a, b: bus_io.cmd_b};
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_comb begin
        // NOTE: every output starts from its held value, so no path leaves a latch.
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        alu_shift_d = alu_shift_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_co_d    = rsp_co_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    alu_a_d     = head.a;
                    alu_b_d     = head.b;
                    alu_sel_d   = head.sel;
                    alu_shift_d = head.shift;
                    state_d     = DRIVE;
                end
            end
            DRIVE: state_d = EXEC;
            EXEC:  state_d = CAPT;
            CAPT: begin
                rsp_data_d  = bus_io.alu_result;
                rsp_co_d    = bus_io.alu_co;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus_io.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_shift_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_co_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            alu_shift_q <= alu_shift_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_co_q    <= rsp_co_d;
        end
    end

`ifdef ALU_CMD_SEQ_OVF_EN
    logic rsp_ovf_q, rsp_ovf_d, ovf_now;

    // Signed overflow judged against the operands still held on alu_a/alu_b.
    always_comb begin
        case (alu_sel_q)
            2'b00:   ovf_now = (alu_a_q[31] == alu_b_q[31]) && (bus_io.alu_result[31] != alu_a_q[31]);
            2'b01:   ovf_now = (alu_a_q[31] != alu_b_q[31]) && (bus_io.alu_result[31] != alu_a_q[31]);
            default: ovf_now = 1'b0;
        endcase
    end

    assign rsp_ovf_d = (state_q == CAPT) ? ovf_now : rsp_ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rsp_ovf_q <= 1'b0;
        else         rsp_ovf_q <= rsp_ovf_d;
    end

    assign bus_io.rsp_ovf = rsp_ovf_q;
`endif

    assign bus_io.cmd_ready = !full;
    assign bus_io.alu_a     = alu_a_q;
    assign bus_io.alu_b     = alu_b_q;
    assign bus_io.alu_sel   = alu_sel_q;
    assign bus_io.alu_shift = alu_shift_q;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_data  = rsp_data_q;
    assign bus_io.rsp_co    = rsp_co_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural two-cycle ALU downstream.
// Builds with or without ALU_CMD_SEQ_OVF_EN.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]  sel;
        logic        shift;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        co;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    bit   rand_rdy = 1'b0;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    // Downstream ALU: a/b registered each cycle, result registered from them
    // using the live sel/shift.
    function automatic logic [32:0] alu_f(input logic [1:0] sel, input logic sh,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (sel)
            2'b00: s = {1'b0, a} + {1'b0, b};
            2'b01: s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            2'b10: begin
                s = {1'b0, a} + {1'b0, b};
                s[31:0] = sh ? (s[31:0] >> 1) : (s[31:0] << 1);
            end
            default: s = {1'b0, a[31:16], b[15:0]};
        endcase
        return s;
    endfunction

    function automatic logic ovf_f(input logic [1:0] sel, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] r);
        if (sel == 2'b00) return (a[31] == b[31]) && (r[31] != a[31]);
        if (sel == 2'b01) return (a[31] != b[31]) && (r[31] != a[31]);
        return 1'b0;
    endfunction

    logic [31:0] alu_ra, alu_rb;
    logic [32:0] alu_out;
    always_ff @(posedge clk) begin
        alu_ra  <= bus.alu_a;
        alu_rb  <= bus.alu_b;
        alu_out <= alu_f(bus.alu_sel, bus.alu_shift, alu_ra, alu_rb);
    end
    assign bus.alu_result = alu_out[31:0];
    assign bus.alu_co     = alu_out[32];

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: pops on each handshake and checks stability while stalled.
    exp_t        mon_e;
    logic        held_v = 1'b0;
    logic [31:0] held_d;
    logic        held_c;
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (held_v) begin
                check("stall_data", bus.rsp_data, held_d);
                check("stall_co", 32'(bus.rsp_co), 32'(held_c));
            end
            if (bus.rsp_ready) begin
                check("rsp_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rsp_data", bus.rsp_data, mon_e.data);
                    check("rsp_co", 32'(bus.rsp_co), 32'(mon_e.co));
`ifdef ALU_CMD_SEQ_OVF_EN
                    check("rsp_ovf", 32'(bus.rsp_ovf), 32'(mon_e.ovf));
`endif
                end
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held_d = bus.rsp_data;
                held_c = bus.rsp_co;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send(input vec_t v, input bit track);
        logic rdy;
        bus.cmd_sel   = v.sel;
        bus.cmd_shift = v.shift;
        bus.cmd_a     = v.a;
        bus.cmd_b     = v.b;
        bus.cmd_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rdy = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                if (track) sb.push_back('{data: v.data, co: v.co, ovf: v.ovf});
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        bus.cmd_valid = 1'b0;
        expire("send_accept");
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 500; n++) begin
            if (sb.size() == 0 && !bus.rsp_valid) return;
            @(posedge clk);
            #1;
        end
        expire(name);
    endtask

    vec_t b2b [6];
    initial begin
        b2b[0] = '{2'b00, 1'b0, 32'd10,         32'd20,         32'h0000001E, 1'b0, 1'b0};
        b2b[1] = '{2'b01, 1'b0, 32'd3,          32'd5,          32'hFFFFFFFE, 1'b0, 1'b0};
        b2b[2] = '{2'b10, 1'b0, 32'hFFFFFFFF,   32'd2,          32'h00000002, 1'b1, 1'b0};
        b2b[3] = '{2'b10, 1'b1, 32'd6,          32'd2,          32'h00000004, 1'b0, 1'b0};
        b2b[4] = '{2'b11, 1'b0, 32'h12345678,   32'h9ABCDEF0,   32'h1234DEF0, 1'b0, 1'b0};
        b2b[5] = '{2'b00, 1'b0, 32'hFFFFFFFF,   32'd1,          32'h00000000, 1'b1, 1'b0};
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   acc;
        vec_t v;
        logic [32:0] r;

        bus.cmd_valid = 1'b0;
        bus.cmd_sel   = '0;
        bus.cmd_shift = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_co", 32'(bus.rsp_co), 32'd0);
`ifdef ALU_CMD_SEQ_OVF_EN
        check("rst_rsp_ovf", 32'(bus.rsp_ovf), 32'd0);
`endif
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("idle_alu_a", bus.alu_a, 32'd0);
            check("idle_alu_b", bus.alu_b, 32'd0);
            check("idle_alu_sel", 32'(bus.alu_sel), 32'd0);
            check("idle_alu_shift", 32'(bus.alu_shift), 32'd0);
        end

        // 5+3: operands appear one edge after accept, response four edges after.
        send('{2'b00, 1'b0, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0}, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                check("drive_alu_a", bus.alu_a, 32'd5);
                check("drive_alu_b", bus.alu_b, 32'd3);
                check("drive_alu_sel", 32'(bus.alu_sel), 32'd0);
            end
        end
        check("accept_to_valid", n, 4);
        wait_drain("drain_add");

        send('{2'b01, 1'b0, 32'd5, 32'd3, 32'd2, 1'b1, 1'b0}, 1'b1);
        wait_drain("drain_sub");

        send('{2'b00, 1'b0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1}, 1'b1);
        send('{2'b01, 1'b0, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b1}, 1'b1);
        send('{2'b00, 1'b0, 32'd5,        32'd3, 32'd8,        1'b0, 1'b0}, 1'b1);
        wait_drain("drain_ovf");

        // Fill with the response stalled: 4 queued plus 1 dispatched.
        bus.rsp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            bus.cmd_sel   = b2b[k].sel;
            bus.cmd_shift = b2b[k].shift;
            bus.cmd_a     = b2b[k].a;
            bus.cmd_b     = b2b[k].b;
            bus.cmd_valid = 1'b1;
            if (!bus.cmd_ready) break;
            @(posedge clk);
            #1;
            sb.push_back('{data: b2b[k].data, co: b2b[k].co, ovf: b2b[k].ovf});
            acc++;
        end
        check("accepts_until_full", acc, 5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        send(b2b[5], 1'b1);
        wait_drain("drain_full");

        rand_rdy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            v.sel   = 2'($urandom_range(0, 3));
            v.shift = 1'($urandom_range(0, 1));
            v.a     = $urandom;
            v.b     = $urandom;
            r       = alu_f(v.sel, v.shift, v.a, v.b);
            v.data  = r[31:0];
            v.co    = r[32];
            v.ovf   = ovf_f(v.sel, v.a, v.b, r[31:0]);
            send(v, 1'b1);
        end
        wait_drain("drain_random");
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;

        // Reset during EXEC with two commands still queued: nothing may come out.
        send(b2b[0], 1'b0);
        send(b2b[1], 1'b0);
        send(b2b[3], 1'b0);
        check("exec_alu_a", bus.alu_a, b2b[0].a);
        rst_n = 1'b0;
        #1;
        check("rst_async_alu_a", bus.alu_a, 32'd0);
        check("rst_async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        check("post_rst_alu_sel", 32'(bus.alu_sel), 32'd0);

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
